wptr_full: RTL and testbench

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/wptr_full.sv | 88 ++++++++
 tb/tb_wptr_full.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wptr_full.sv
// Write-side pointer and full-flag logic for an asynchronous FIFO.
// Define WPTR_ALMOST_FULL_EN to build the registered almost-full flag (wafull).
module wptr_full #(
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [ADDR_W:0]   rq2_wptr,
  output logic              wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull
`ifdef WPTR_ALMOST_FULL_EN
  ,
  output logic              wafull
`endif
);

  // The full compare inverts the two top Gray bits, so at least two are needed.
  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("wptr_full: ADDR_W must be at least 2");
  end
  if (AFULL_LVL < 0 || AFULL_LVL > 2**ADDR_W) begin : g_bad_afull_lvl
    $error("wptr_full: AFULL_LVL must lie in 0..2**ADDR_W");
  end

  logic [ADDR_W:0] wbin_q, wbin_d;
  logic [ADDR_W:0] wptr_q, wgray_d;
  logic            wfull_q, wfull_d;
  logic [ADDR_W:0] full_match;

  assign wen        = winc & ~wfull_q;
  assign waddr      = wbin_q[ADDR_W-1:0];
  assign wptr       = wptr_q;
  assign wfull      = wfull_q;

  // The writer is exactly one lap ahead when the top two Gray bits differ.
  assign full_match = {~rq2_wptr[ADDR_W:ADDR_W-1], rq2_wptr[ADDR_W-2:0]};

  always_comb begin
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wen};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    wfull_d = (wgray_d == full_match);
  end

  // NOTE: state registers use non-blocking assignments so every register samples
  // the pre-edge values computed above; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wptr_q  <= '0;
      wfull_q <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      wfull_q <= wfull_d;
    end
  end

`ifdef WPTR_ALMOST_FULL_EN
  localparam logic [ADDR_W:0] AFULL_THR = (ADDR_W+1)'(2**ADDR_W - AFULL_LVL);

  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] used_d;
  logic            wafull_q, wafull_d;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rbin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      rbin[i] = ^(rq2_wptr >> i);
    end
    used_d   = wbin_d - rbin;
    wafull_d = (used_d >= AFULL_THR);
  end

  always_ff @(posedge clk) begin
    if (rst) wafull_q <= 1'b0;
    else     wafull_q <= wafull_d;
  end

  assign wafull = wafull_q;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed fill/full/release/wrap/reset
// scenarios plus randomized traffic against an occupancy-count model.
module tb_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 2**AW;
  localparam int LAP   = 2*DEPTH;
  localparam int AFL   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          winc;
  logic [AW:0]   rq2_wptr;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [AW:0]   wptr;
  logic          wfull;
`ifdef WPTR_ALMOST_FULL_EN
  logic          wafull;
`endif

  int rd_cnt;           // reader position, counted in writes consumed (mod LAP)
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = AW'(0) + (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  assign rq2_wptr = to_gray(rd_cnt);

  wptr_full #(.ADDR_W(AW), .AFULL_LVL(AFL)) dut (
    .clk      (clk),
    .rst      (rst),
    .winc     (winc),
    .rq2_wptr (rq2_wptr),
    .wen      (wen),
    .waddr    (waddr),
    .wptr     (wptr),
    .wfull    (wfull)
`ifdef WPTR_ALMOST_FULL_EN
    ,
    .wafull   (wafull)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: writes accepted so far (mod LAP) and the flags derived from occupancy.
  int m_wcnt;
  bit m_full, m_afull, m_armed, m_was_rst;

  always @(posedge clk) begin
    int acc, nw, occ;
    if (rst) begin
      m_wcnt    <= 0;
      m_full    <= 1'b0;
      m_afull   <= 1'b0;
      m_armed   <= 1'b1;
      m_was_rst <= 1'b1;
    end else begin
      acc = (winc && !m_full) ? 1 : 0;
      nw  = (m_wcnt + acc) % LAP;
      occ = (nw - rd_cnt + LAP) % LAP;
      m_wcnt    <= nw;
      m_full    <= (occ == DEPTH);
      m_afull   <= (occ >= DEPTH - AFL);
      m_was_rst <= 1'b0;
    end
  end

  // Compare process: checks every output on every falling edge once reset has been seen.
  logic [AW:0] prev_wptr;
  always @(negedge clk) begin
    if (m_armed) begin
      check("wptr",  32'(wptr),  32'(to_gray(m_wcnt)));
      check("waddr", 32'(waddr), 32'(m_wcnt % DEPTH));
      check("wfull", 32'(wfull), 32'(m_full));
      check("wen",   32'(wen),   32'(winc && !m_full));
`ifdef WPTR_ALMOST_FULL_EN
      check("wafull", 32'(wafull), 32'(m_afull));
`endif
      if (!m_was_rst) check("gray_step", 32'($countones(prev_wptr ^ wptr) <= 1), 32'(1));
      prev_wptr = wptr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    winc   = 1'b0;
    rd_cnt = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int d1, d2;
    rst    = 1'b1;
    winc   = 1'b0;
    rd_cnt = 0;
    do_reset();
    check("reset_wptr",  32'(wptr),  32'h0);
    check("reset_wfull", 32'(wfull), 32'h0);
    check("reset_waddr", 32'(waddr), 32'h0);

    // Fill all 16 slots with the reader parked at 0.
    winc = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("fill_wfull_before_last", 32'(wfull), 32'h0);
      tick();
    end
    check("fill_wfull", 32'(wfull), 32'h1);
    check("fill_wptr",  32'(wptr),  32'b11000);
    check("fill_waddr", 32'(waddr), 32'h0);

    // Keep requesting while full: nothing may move.
    for (int i = 0; i < 5; i++) begin
      check("full_wen",   32'(wen),   32'h0);
      tick();
      check("full_wptr",  32'(wptr),  32'b11000);
      check("full_waddr", 32'(waddr), 32'h0);
    end

    // Reader consumes one entry: full drops on the next edge, and wen rises.
    rd_cnt = 1;
    tick();
    check("release_wfull", 32'(wfull), 32'h0);
    check("release_wen",   32'(wen),   32'h1);
    winc = 1'b0;
    tick();

    // Reset mid-stream after 7 writes with a write still requested.
    do_reset();
    winc = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    check("mid_wptr_before", 32'(wptr), 32'(to_gray(7)));
    rst = 1'b1;
    tick();
    check("mid_rst_wptr",  32'(wptr),  32'h0);
    check("mid_rst_waddr", 32'(waddr), 32'h0);
    check("mid_rst_wfull", 32'(wfull), 32'h0);
    rst  = 1'b0;
    winc = 1'b0;
    tick();
    check("mid_rst_hold", 32'(wptr), 32'h0);

    // Wrap: 40 writes with the reader two cycles behind the writer.
    do_reset();
    winc = 1'b1;
    d1 = 0;
    d2 = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      rd_cnt = d2;
      d2 = d1;
      d1 = i % LAP;
      check("wrap_nofull", 32'(wfull), 32'h0);
      if (i == 32) check("wrap_wptr_zero", 32'(wptr), 32'h0);
    end
    winc = 1'b0;
    tick();

`ifdef WPTR_ALMOST_FULL_EN
    // Almost-full: level 2 means the flag rises once 14 slots are used.
    do_reset();
    winc = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 13) check("afull_13", 32'(wafull), 32'h0);
      if (i == 14) check("afull_14", 32'(wafull), 32'h1);
    end
    winc = 1'b0;
    tick();
`endif

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int occ;
      if ($urandom_range(0, 299) == 0) begin
        rst    = 1'b1;
        rd_cnt = 0;
      end else begin
        rst = 1'b0;
        occ = (m_wcnt - rd_cnt + LAP) % LAP;
        if (occ > 0 && $urandom_range(0, 2) == 0) rd_cnt = (rd_cnt + 1) % LAP;
      end
      winc = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst  = 1'b0;
    winc = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
